// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. A shadow register holds four hex digits, the decimal
// points and a blank mask. One digit is scanned per TICK_DIV-cycle slot.
// New data arrives over a req/ack handshake and is committed only at a frame
// boundary, or immediately while the display is disabled.
//
// Build option: define LZ_SUPPRESS_EN to blank leading zeros. Digit 0 is
// never suppressed, and a lit decimal point stops suppression at that digit.
//
// Ports:
//   mclk       system clock
//   rst_n      asynchronous reset, active-low
//   en         display enable (low: all digits dark, scan held at digit 0)
//   upd_req    update request level, held until upd_ack
//   upd_val    hex digits, [3:0] = digit 0 (rightmost)
//   upd_dp     decimal point per digit, 1 = lit
//   upd_blank  per-digit blank, 1 = dark
//   upd_ack    one-cycle pulse: request captured into the shadow
//   an         anodes, active-low, at most one low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
module seg_scan_ctrl #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_req,
  input  logic [15:0] upd_val,
  input  logic [3:0]  upd_dp,
  input  logic [3:0]  upd_blank,
  output logic        upd_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      sh_val;
  logic [3:0]       sh_dp;
  logic [3:0]       sh_blank;
  logic             cap_q;

  logic       tick;
  logic       frame;
  logic       cap;
  logic [3:0] lz;
  logic [3:0] dark;
  logic [3:0] nib;
  logic [6:0] glyph;

  assign tick  = en && (cnt == CNT_MAX);
  assign frame = tick && (idx == 2'd3);
  // A capture already in flight (ack not yet seen upstream) blocks a repeat
  // capture of the same request; this matters while en is low, where any
  // cycle may capture.
  assign cap   = upd_req && !cap_q && !upd_ack && (frame || !en);

  // Slot prescaler and digit index; both parked at 0 while disabled.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (!en) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow register; cap_q delays a boundary ack so it lines up with the
  // first registered digit-0 output of the new frame.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val   <= 16'h0000;
      sh_dp    <= 4'h0;
      sh_blank <= 4'h0;
      cap_q    <= 1'b0;
    end else begin
      if (cap) begin
        sh_val   <= upd_val;
        sh_dp    <= upd_dp;
        sh_blank <= upd_blank;
      end
      cap_q <= cap && frame;
    end
  end

  // Leading-zero mask, from the top digit down.
  always_comb begin
    lz = 4'h0;
`ifdef LZ_SUPPRESS_EN
    lz[3] = (sh_val[15:12] == 4'h0) && !sh_dp[3];
    lz[2] = lz[3] && (sh_val[11:8] == 4'h0) && !sh_dp[2];
    lz[1] = lz[2] && (sh_val[7:4] == 4'h0) && !sh_dp[1];
`endif
  end

  assign dark = sh_blank | lz;

  // Nibble for the digit currently scanned.
  always_comb begin
    nib = sh_val[3:0];
    case (idx)
      2'd0: nib = sh_val[3:0];
      2'd1: nib = sh_val[7:4];
      2'd2: nib = sh_val[11:8];
      2'd3: nib = sh_val[15:12];
      default: nib = sh_val[3:0];
    endcase
  end

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    glyph = 7'b1111111;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  end

  // Registered output stage, one cycle behind idx/shadow. A capture while
  // disabled acks at once since there is no digit output to align with.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      an      <= 4'b1111;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
      upd_ack <= 1'b0;
    end else begin
      an      <= (en && !dark[idx]) ? ~(4'b0001 << idx) : 4'b1111;
      seg     <= glyph;
      dp      <= ~sh_dp[idx];
      upd_ack <= (cap && !en) || cap_q;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the board's 4-digit common-anode 7-segment display. Holds a 16-bit hex value, per-digit decimal points and a blank mask in a shadow register, and scans one digit at a time at a programmable rate. It drives the anodes, segments and decimal point directly. New display data is accepted through a req/ack handshake and committed only at a frame boundary, so a frame never mixes old and new digits.

## Interface
- TICK_DIV, 100000: mclk cycles per digit slot (500 Hz slot rate at 50 MHz); legal range is 2 to 2^20.
- mclk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  display enable; when low, all digits are dark.
- upd_req  input  1  update request; level signal, held until upd_ack.
- upd_val  input  16  hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- upd_dp  input  4  decimal point per digit, 1 = lit.
- upd_blank  input  4  per-digit blank, 1 = digit dark.
- upd_ack  output  1  one-cycle pulse: data captured into shadow.
- an  output  4  anodes, active-low, at most one bit low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- Prescaler cnt counts 0 to TICK_DIV-1 and wraps. tick = (cnt == TICK_DIV-1) && en.
- Digit index idx (2 bits) advances 0→1→2→3→0 on each tick. A frame boundary is a tick with idx == 3.
- Shadow capture: if upd_req is high on a frame-boundary tick, the shadow loads {upd_val, upd_dp, upd_blank} and upd_ack pulses on the next cycle.
- Shadow capture while en == 0: if upd_req is high, capture happens on any cycle.
- Upstream must hold data stable while upd_req is high and drop upd_req in the cycle after upd_ack. If upd_req is still high at the next boundary, a second capture and ack occur; this is legal.
- When en == 0, cnt and idx are held at 0 and an = 4'b1111. When en rises, scanning restarts at digit 0.
- Output stage (all registered):
  - an = ~(1 << idx), except 4'b1111 when the digit is blanked or en == 0.
  - seg = hex decode of shadow nibble[idx], standard 0–F glyphs. Examples: 0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110.
  - dp = ~shadow_dp[idx].
- Reset values:
  - cnt = 0, idx = 0, shadow = all zeros.
  - an = 4'b1111, seg = 7'b1111111, dp = 1, upd_ack = 0.

## Timing
- Outputs lag idx/shadow by exactly 1 cycle. An anode change is seen 1 cycle after the tick edge.
- On a capture, upd_ack and the first new-data digit-0 outputs appear on the same cycle.
- Each digit slot lasts exactly TICK_DIV cycles. A frame lasts 4·TICK_DIV cycles.
- Worst-case update latency is 4·TICK_DIV + 1 cycles from upd_req rising to upd_ack.
- en falls mid-frame: an = 4'b1111 on the next cycle, idx resets to 0, and a pending upd_req is captured on that same edge.
- en and a frame-boundary tick on the same edge: en low has priority; the tick is suppressed.
- rst_n asserted mid-frame or mid-handshake: all state returns to reset values immediately, and no ack is issued for the aborted request.
- cnt width is ceil(log2(TICK_DIV)). The wrap comparison is exact, so there is no extra cycle at the wrap.

## Configuration
- LZ_SUPPRESS_EN defined: leading zeros are blanked. Digit 3 is blanked if its nibble is 0, digit 2 if nibbles 3 and 2 are both 0, digit 1 if nibbles 3..1 are all 0. Digit 0 is never suppressed.
  - Decimal points are unaffected: a digit with its dp set is never suppressed, and neither is any lower digit.
  - Suppression is ORed with upd_blank.
- LZ_SUPPRESS_EN not defined: all non-blanked digits are displayed, including zeros.

## Test plan
- Reset and scan: TICK_DIV = 4, en = 1, release rst_n.
  - an is 4'b1111 during reset, then 1110 for 4 cycles, then 1101, 1011, 0111, 1110, repeating.
  - seg = 7'b1000000 throughout.
- Boundary commit: assert upd_req with upd_val = 16'h12AF in the middle of digit 1.
  - No seg change until the frame wrap.
  - upd_ack pulses once, in the same cycle as an = 1110 with seg = F glyph 7'b0001110.
  - The rest of the frame shows A, 2, 1.
- Blank/dp: upd_blank = 4'b0100, upd_dp = 4'b0001.
  - Digit 2 slot has an = 1111.
  - Digit 0 slot has dp = 0; all other slots have dp = 1.
- Enable: drop en during digit 2 with upd_req high.
  - Next cycle an = 1111 and upd_ack pulses.
  - Re-raise en: scan restarts at an = 1110 with a full 4-cycle slot.
- Leading zeros, with LZ_SUPPRESS_EN defined: upd_val = 16'h0030.
  - Digits 3 and 2 are dark; digits 1 and 0 show 3 and 0.
  - Without LZ_SUPPRESS_EN, all four digits are lit.
- Async reset mid-handshake: pulse rst_n low while upd_req is high.
  - Outputs return to reset values within the same cycle.
  - No upd_ack occurs until the next frame boundary.
